// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: walks a one-cold active-low column drive across
// NUM_COLS columns, synchronises and debounces the active-low row lines and
// reports each accepted key as row*NUM_COLS+col with a one-cycle strobe.
// Optional auto-repeat of the strobe while a key is held is enabled by
// defining KEYPAD_AUTOREPEAT_EN; the default build gives one strobe per press.
module keypad_scanner #(
  parameter int NUM_ROWS        = 4,
  parameter int NUM_COLS        = 4,
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_RATE     = 16,
  localparam int KW = $clog2(NUM_ROWS * NUM_COLS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_ROWS-1:0] kpr,
  output logic [NUM_COLS-1:0] kpc,
  output logic [KW-1:0]       key_code,
  output logic                key_strobe,
  output logic                key_held
);

  localparam int CW = $clog2(NUM_COLS);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int HW = $clog2(REPEAT_DELAY + 1);
`endif

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t              state_q;
  logic [NUM_ROWS-1:0] sync1_q, kpr_s, snap_q;
  logic [CW-1:0]       col_q, next_col;
  logic [DW-1:0]       dwell_q;
  logic [BW-1:0]       cnt_q;
  logic [KW-1:0]       acc_code;
  logic                detect, accept, rel_done;
`ifdef KEYPAD_AUTOREPEAT_EN
  logic [HW-1:0]       hold_q;
`endif

  // Active-low drive pattern for a column index: column c is bit NUM_COLS-1-c.
  function automatic logic [NUM_COLS-1:0] col_drive(input logic [CW-1:0] col);
    logic [NUM_COLS-1:0] d;
    for (int c = 0; c < NUM_COLS; c++) d[NUM_COLS-1-c] = (int'(col) != c);
    return d;
  endfunction

  // Lowest-indexed low row wins when several rows are pressed together.
  function automatic logic [RW-1:0] first_low(input logic [NUM_ROWS-1:0] r);
    logic [RW-1:0] idx;
    idx = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) if (!r[i]) idx = RW'(i);
    return idx;
  endfunction

  assign next_col = (col_q == CW'(NUM_COLS - 1)) ? '0 : col_q + CW'(1);
  assign acc_code = KW'(int'(first_low(kpr_s)) * NUM_COLS + int'(col_q));
  // Rows are only trusted once the settle window (dwell 0..2) has passed.
  assign detect   = (dwell_q >= DW'(3)) && (kpr_s != '1);
  assign accept   = ((state_q == SCAN) && detect && (DEBOUNCE_CYCLES == 1)) ||
                    ((state_q == DEBOUNCE) && (kpr_s == snap_q) &&
                     (cnt_q == BW'(DEBOUNCE_CYCLES - 1)));
  assign rel_done = (kpr_s == '1) && (cnt_q == BW'(DEBOUNCE_CYCLES - 1));

  // Two-flop synchroniser on the asynchronous row lines; idles high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      kpr_s   <= '1;
    end else begin
      sync1_q <= kpr;
      kpr_s   <= sync1_q;
    end
  end

  // Scan / debounce / held sequencer with registered column drive and outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SCAN;
      col_q      <= '0;
      kpc        <= col_drive('0);
      dwell_q    <= '0;
      cnt_q      <= '0;
      snap_q     <= '1;
      key_code   <= '0;
      key_strobe <= 1'b0;
      key_held   <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      hold_q     <= '0;
`endif
    end else begin
      key_strobe <= 1'b0;
      if (accept) begin
        state_q    <= HELD;
        key_code   <= acc_code;
        key_held   <= 1'b1;
        key_strobe <= 1'b1;
        cnt_q      <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
        hold_q     <= '0;
`endif
      end else begin
        case (state_q)
          SCAN: begin
            if (detect) begin
              // Column freezes here until the key is released or rejected.
              snap_q  <= kpr_s;
              cnt_q   <= BW'(1);
              state_q <= DEBOUNCE;
            end else if (dwell_q == DW'(SCAN_DIV - 1)) begin
              col_q   <= next_col;
              kpc     <= col_drive(next_col);
              dwell_q <= '0;
            end else begin
              dwell_q <= dwell_q + DW'(1);
            end
          end
          DEBOUNCE: begin
            if (kpr_s != snap_q) begin
              // Bounce: resume scanning on this column, already settled.
              state_q <= SCAN;
              dwell_q <= DW'(3);
            end else begin
              cnt_q <= cnt_q + BW'(1);
            end
          end
          HELD: begin
            if (kpr_s != '1) begin
              cnt_q <= '0;
            end else if (rel_done) begin
              state_q  <= SCAN;
              key_held <= 1'b0;
              col_q    <= next_col;
              kpc      <= col_drive(next_col);
              dwell_q  <= '0;
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_q + BW'(1);
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            // First repeat REPEAT_DELAY after acceptance, then every REPEAT_RATE.
            if (rel_done) begin
              hold_q <= '0;
            end else if (hold_q == HW'(REPEAT_DELAY - 1)) begin
              key_strobe <= 1'b1;
              hold_q     <= HW'(REPEAT_DELAY - REPEAT_RATE);
            end else begin
              hold_q <= hold_q + HW'(1);
            end
`endif
          end
          default: state_q <= SCAN;
        endcase
      end
    end
  end

endmodule
